// File: rtl/ball_move_rect.sv
// ball_move_rect: fixed-point ball motion, per-pixel window test and pop sequence.
// Optional feature macro: BALL_GRAVITY_EN. Defined, the ball follows gravity arcs.
// Undefined, it bounces diagonally at constant speed.
module ball_move_rect #(
    parameter int INIT_X         = 100,
    parameter int INIT_Y         = 50,
    parameter int INIT_SPEED_X   = 64,
    parameter int BOUNCE_SPEED_Y = -256,
    parameter int GRAVITY        = 4,
    parameter int OBJECT_WIDTH   = 20,
    parameter int OBJECT_HEIGHT  = 20,
    parameter int LEFT_WALL      = 0,
    parameter int RIGHT_WALL     = 639,
    parameter int FLOOR_Y        = 479,
    parameter int POP_FRAMES     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        hit,
    input  logic        launch,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        visible,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        popped
);
    localparam int CntW = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(POP_FRAMES - 1);
    localparam logic signed [16:0] InitPosX  = 17'(INIT_X * 64);
    localparam logic signed [16:0] InitPosY  = 17'(INIT_Y * 64);
    localparam logic signed [16:0] FloorPosY = 17'((FLOOR_Y - OBJECT_HEIGHT) * 64);
    localparam logic signed [11:0] InitSpdX  = 12'(INIT_SPEED_X);
    localparam logic signed [11:0] BounceSpdY = 12'(BOUNCE_SPEED_Y);
`ifdef BALL_GRAVITY_EN
    localparam logic signed [11:0] GravityStep = 12'(GRAVITY);
    localparam logic signed [11:0] InitSpdY    = 12'sd0;
`else
    // Without gravity the per-frame increment is a constant zero.
    localparam logic signed [11:0] GravityStep = 12'(GRAVITY * 0);
    localparam logic signed [11:0] InitSpdY    = BounceSpdY;
`endif

    typedef enum logic [1:0] {StAlive, StPopping, StDead} state_e;

    state_e             state_q, state_d;
    logic signed [16:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [11:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               popped_d, visible_d, inside_d;
    logic [10:0]        off_x_d, off_y_d;
    logic signed [10:0] tl_x, tl_y;
    logic signed [11:0] spd_x_f, spd_y_f;
    logic signed [16:0] pos_y_base;
    logic [11:0]        win_x_end, win_y_end;

    assign tl_x     = pos_x_q[16:6];
    assign tl_y     = pos_y_q[16:6];
    assign topLeftX = pos_x_q[16:6];
    assign topLeftY = pos_y_q[16:6];

    // Speeds after gravity and bounces for the frame; all tests use the pre-frame position
    always_comb begin
        spd_y_f    = spd_y_q + GravityStep;
        spd_x_f    = spd_x_q;
        pos_y_base = pos_y_q;
        if ((int'(tl_y) + OBJECT_HEIGHT >= FLOOR_Y) && (spd_y_f > 12'sd0)) begin
`ifdef BALL_GRAVITY_EN
            spd_y_f = BounceSpdY;
`else
            spd_y_f = -spd_y_f;
`endif
            pos_y_base = FloorPosY;
        end
        if ((tl_y <= 11'sd0) && (spd_y_f < 12'sd0)) spd_y_f = -spd_y_f;
        if ((int'(tl_x) <= LEFT_WALL) && (spd_x_f < 12'sd0)) spd_x_f = -spd_x_f;
        if ((int'(tl_x) + OBJECT_WIDTH >= RIGHT_WALL) && (spd_x_f > 12'sd0)) begin
            spd_x_f = -spd_x_f;
        end
    end

    // Life-cycle FSM and motion next-state; launch overrides everything
    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        spd_x_d  = spd_x_q;
        spd_y_d  = spd_y_q;
        cnt_d    = cnt_q;
        popped_d = 1'b0;
        if (launch) begin
            state_d = StAlive;
            pos_x_d = InitPosX;
            pos_y_d = InitPosY;
            spd_x_d = InitSpdX;
            spd_y_d = InitSpdY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StAlive: begin
                    if (hit) begin
                        state_d = StPopping;
                        cnt_d   = '0;
                    end else if (startOfFrame) begin
                        spd_x_d = spd_x_f;
                        spd_y_d = spd_y_f;
                        pos_x_d = pos_x_q + {{5{spd_x_f[11]}}, spd_x_f};
                        pos_y_d = pos_y_base + {{5{spd_y_f[11]}}, spd_y_f};
                    end
                end
                StPopping: begin
                    if (startOfFrame) begin
                        if (cnt_q == CntLast) begin
                            state_d  = StDead;
                            popped_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StDead: begin
                end
                default: state_d = StAlive;
            endcase
        end
    end

    // Window test against the current position, and visibility of the upcoming state
    always_comb begin
        win_x_end = {1'b0, topLeftX} + 12'(OBJECT_WIDTH);
        win_y_end = {1'b0, topLeftY} + 12'(OBJECT_HEIGHT);
        inside_d  = (pixelX >= topLeftX) && ({1'b0, pixelX} < win_x_end) &&
                    (pixelY >= topLeftY) && ({1'b0, pixelY} < win_y_end);
        off_x_d   = inside_d ? (pixelX - topLeftX) : 11'd0;
        off_y_d   = inside_d ? (pixelY - topLeftY) : 11'd0;
        visible_d = 1'b0;
        case (state_d)
            StAlive:   visible_d = 1'b1;
            StPopping: visible_d = ~cnt_d[0];
            default:   visible_d = 1'b0;
        endcase
    end

    // State, motion and registered pixel outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StAlive;
            pos_x_q         <= InitPosX;
            pos_y_q         <= InitPosY;
            spd_x_q         <= InitSpdX;
            spd_y_q         <= InitSpdY;
            cnt_q           <= '0;
            offsetX         <= 11'd0;
            offsetY         <= 11'd0;
            InsideRectangle <= 1'b0;
            visible         <= 1'b0;
            popped          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pos_x_q         <= pos_x_d;
            pos_y_q         <= pos_y_d;
            spd_x_q         <= spd_x_d;
            spd_y_q         <= spd_y_d;
            cnt_q           <= cnt_d;
            offsetX         <= off_x_d;
            offsetY         <= off_y_d;
            InsideRectangle <= inside_d;
            visible         <= visible_d;
            popped          <= popped_d;
        end
    end

endmodule

// File: tb/tb_ball_move_rect.sv
// tb_ball_move_rect: vector table, directed pop/launch/reset sequences and randomized
// stimulus checked against a behavioural model of the ball.
module tb_ball_move_rect;
    localparam int INIT_X = 100, INIT_Y = 50, INIT_SPEED_X = 64, BOUNCE = -256, GRAV = 4;
    localparam int W = 20, H = 20, LW = 0, RW = 639, FLOOR = 479, POP = 8;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, hit, launch;
    logic [10:0] pixelX, pixelY;
    logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
    logic        InsideRectangle, visible, popped;

    ball_move_rect dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .hit(hit), .launch(launch),
        .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
        .visible(visible), .topLeftX(topLeftX), .topLeftY(topLeftY), .popped(popped)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    // Model: position and speed as plain integers in 1/64 px; state 0 alive, 1 popping, 2 dead
    int m_px, m_py, m_sx, m_sy, m_state, m_cnt;
    int e_in, e_ox, e_oy, e_vis, e_pop;
    bit ev_floor, ev_right;
    int floor_n = 0, right_n = 0, popped_seen = 0;

    typedef struct { int px; int py; int ins; int ox; int oy; } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_init();
        m_px = INIT_X * 64; m_py = INIT_Y * 64; m_sx = INIT_SPEED_X;
`ifdef BALL_GRAVITY_EN
        m_sy = 0;
`else
        m_sy = BOUNCE;
`endif
        m_state = 0; m_cnt = 0;
    endtask

    function automatic int tl_of(input int p);
        return (p >>> 6) & 2047;
    endfunction

    task automatic model_step(input bit sof, input bit h, input bit l, input int pxl, input int pyl);
        int tlx, tly, ux, uy;
        tlx = m_px >>> 6; tly = m_py >>> 6;
        ux = tlx & 2047; uy = tly & 2047;
        e_in = (pxl >= ux && pxl < ux + W && pyl >= uy && pyl < uy + H) ? 1 : 0;
        e_ox = e_in ? pxl - ux : 0;
        e_oy = e_in ? pyl - uy : 0;
        e_pop = 0; ev_floor = 0; ev_right = 0;
        if (l) model_init();
        else if (m_state == 0) begin
            if (h) begin m_state = 1; m_cnt = 0; end
            else if (sof) begin
`ifdef BALL_GRAVITY_EN
                m_sy += GRAV;
`endif
                if (tly + H >= FLOOR && m_sy > 0) begin
`ifdef BALL_GRAVITY_EN
                    m_sy = BOUNCE;
`else
                    m_sy = -m_sy;
`endif
                    m_py = (FLOOR - H) * 64;
                    ev_floor = 1;
                end
                if (tly <= 0 && m_sy < 0) m_sy = -m_sy;
                if (tlx <= LW && m_sx < 0) m_sx = -m_sx;
                if (tlx + W >= RW && m_sx > 0) begin m_sx = -m_sx; ev_right = 1; end
                m_px += m_sx; m_py += m_sy;
            end
        end else if (m_state == 1) begin
            if (sof) begin
                if (m_cnt == POP - 1) begin m_state = 2; e_pop = 1; end
                else m_cnt++;
            end
        end
        e_vis = (m_state == 0) ? 1 : (m_state == 1) ? ((m_cnt % 2 == 0) ? 1 : 0) : 0;
    endtask

    task automatic compare_all();
        check("inside", int'(InsideRectangle), e_in);
        check("offsetX", int'(offsetX), e_ox);
        check("offsetY", int'(offsetY), e_oy);
        check("visible", int'(visible), e_vis);
        check("popped", int'(popped), e_pop);
        check("topLeftX", int'(topLeftX), tl_of(m_px));
        check("topLeftY", int'(topLeftY), tl_of(m_py));
    endtask

    // One clock: drive inputs, step the model at the edge, sample just after it
    task automatic cyc(input bit sof, input bit h, input bit l, input int pxl, input int pyl,
                       input bit chk);
        startOfFrame = sof; hit = h; launch = l;
        pixelX = 11'(pxl); pixelY = 11'(pyl);
        @(posedge clk);
        model_step(sof, h, l, pxl, pyl);
        #1;
        if (popped) popped_seen++;
        if (chk) compare_all();
        if (ev_floor) begin check("floor_bounce_y", int'(topLeftY), FLOOR - H - 4); floor_n++; end
        if (ev_right) begin check("right_wall_x", int'(topLeftX), RW - W - 1); right_n++; end
    endtask

    function automatic int near(input int p);
        return ((p >>> 6) + int'($urandom_range(0, 30)) - 5) & 2047;
    endfunction

    task automatic frame_rand(input bit h);
        cyc(1'b1, h, 1'b0, near(m_px), near(m_py), 1'b1);
        cyc(1'b0, h, 1'b0, near(m_px), near(m_py), 1'b1);
        cyc(1'b0, h, 1'b0, near(m_px), near(m_py), 1'b1);
    endtask

    initial begin
        int sx, sy;
        tbl = '{'{99, 50, 0, 0, 0}, '{100, 50, 1, 0, 0}, '{105, 55, 1, 5, 5},
                '{119, 69, 1, 19, 19}, '{120, 60, 0, 0, 0}, '{110, 70, 0, 0, 0},
                '{110, 49, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{105, 69, 1, 5, 19},
                '{2047, 60, 0, 0, 0}};
        reset = 1'b1; startOfFrame = 1'b0; hit = 1'b0; launch = 1'b0;
        pixelX = 11'd0; pixelY = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        model_init();
        check("rst_offsetX", int'(offsetX), 0);
        check("rst_offsetY", int'(offsetY), 0);
        check("rst_inside", int'(InsideRectangle), 0);
        check("rst_visible", int'(visible), 0);
        check("rst_popped", int'(popped), 0);
        check("rst_topLeftX", int'(topLeftX), INIT_X);
        check("rst_topLeftY", int'(topLeftY), INIT_Y);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        check("visible_after_reset", int'(visible), 1);

        // Window sweep with the ball parked at (100,50)
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, tbl[i].px, tbl[i].py, 1'b0);
            check($sformatf("win_ins_%0d", i), int'(InsideRectangle), tbl[i].ins);
            check($sformatf("win_ox_%0d", i), int'(offsetX), tbl[i].ox);
            check($sformatf("win_oy_%0d", i), int'(offsetY), tbl[i].oy);
        end

        // First frame
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        check("frame1_x", int'(topLeftX), 101);
`ifdef BALL_GRAVITY_EN
        check("frame1_y", int'(topLeftY), 50);
`else
        check("frame1_y", int'(topLeftY), 46);
`endif

        // Long flight to reach the floor and the right wall
        for (int f = 0; f < 560; f++) frame_rand(1'b0);
        check("floor_seen", (floor_n > 0) ? 1 : 0, 1);
        check("right_seen", (right_n > 0) ? 1 : 0, 1);

        // Hit together with a frame start: position frozen, then blink and die
        sx = tl_of(m_px); sy = tl_of(m_py);
        popped_seen = 0;
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        check("hit_hold_x", int'(topLeftX), sx);
        check("hit_hold_y", int'(topLeftY), sy);
        for (int k = 0; k < POP; k++) begin
            check($sformatf("pop_vis_%0d", k), int'(visible), (k % 2 == 0) ? 1 : 0);
            cyc(1'b0, 1'b1, 1'b0, sx, sy, 1'b1);
            cyc(1'b1, 1'b0, 1'b0, sx, sy, 1'b1);
        end
        check("popped_pulse", int'(popped), 1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, sx, sy, 1'b1);
        check("popped_once", popped_seen, 1);
        check("dead_vis", int'(visible), 0);
        check("dead_hold_x", int'(topLeftX), sx);
        check("dead_hold_y", int'(topLeftY), sy);
        // Launch wins over hit and frame start
        cyc(1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
        check("launch_x", int'(topLeftX), INIT_X);
        check("launch_y", int'(topLeftY), INIT_Y);
        check("launch_vis", int'(visible), 1);

        // Reset during the fourth popping frame
        frame_rand(1'b0);
        frame_rand(1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) frame_rand(1'b0);
        popped_seen = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_init();
        check("rstpop_x", int'(topLeftX), INIT_X);
        check("rstpop_y", int'(topLeftY), INIT_Y);
        check("rstpop_vis", int'(visible), 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        check("rstpop_vis_after", int'(visible), 1);
        for (int f = 0; f < 10; f++) frame_rand(1'b0);
        check("rstpop_no_popped", popped_seen, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 99) == 0, near(m_px), near(m_py), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
